sitcpxg_tx_arbiter: RTL and testbench
=====================================

Name: sitcpxg_tx_arbiter

Overview:
Shares the single 10GbE SiTCP TCP transmit path (USER_TX_D / USER_TX_B / USER_TX_AFULL) among NUM_CH independent user data sources.
- Each source is a first-word-fall-through FIFO with a packet-end marker.
- Grants are round-robin and packet- or burst-granular.
- Sits between user FIFOs and the SiTCPXG core wrapper in the XGMII_CLOCK (156.25 MHz) domain.
- Honours session state and TX almost-full backpressure.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
MAX_BURST, 256, max 64-bit words popped per grant before forced re-arbitration (1..65535)

Ports:
XGMII_CLOCK  in  1  156.25 MHz clock, all logic on rising edge
RSTn  in  1  asynchronous active-low reset
USER_SESSION_ESTABLISHED  in  1  TCP session up (from SiTCP)
USER_TX_AFULL  in  1  SiTCP TX almost-full
USER_TX_D  out  64  data to SiTCP
USER_TX_B  out  4  valid byte count of USER_TX_D, 0 = no write
CH_ENABLE  in  NUM_CH  per-channel enable mask
CH_EMPTY  in  NUM_CH  FIFO empty, bit i = channel i
CH_D  in  64*NUM_CH  FWFT data, channel i at [64i+63:64i]
CH_B  in  4*NUM_CH  byte count of head word, channel i at [4i+3:4i]
CH_LAST  in  NUM_CH  head word ends a packet
CH_RD  out  NUM_CH  pop strobe, one-hot or zero
CH_GRANT  out  NUM_CH  current owner, one-hot or zero
TX_BYTE_CNT  out  32  total bytes sent, wraps modulo 2^32
ERR_BCNT  out  1  sticky: a popped word had CH_B > 8

Behaviour:
- Reset: all outputs 0. State IDLE. Round-robin pointer = NUM_CH-1, so channel 0 wins first. Burst counter 0. AFULL register 1 (stalled).
- afull_q = USER_TX_AFULL registered once. Total AFULL-to-stop reaction is 2 cycles, covered by SiTCP almost-full margin.
- req[i] = CH_ENABLE[i] & ~CH_EMPTY[i] & USER_SESSION_ESTABLISHED.
- IDLE:
  - If any req, pick the first set req searching from ptr+1 upward, wrapping modulo NUM_CH.
  - Load CH_GRANT one-hot, ptr = winner, burst counter = 0, go XFER.
  - No req: stay IDLE.
- XFER, with g = granted index:
  - CH_RD[g] = ~CH_EMPTY[g] & ~afull_q & USER_SESSION_ESTABLISHED & CH_ENABLE[g]. CH_RD is combinational from registered state and inputs.
  - On a pop, the next edge registers USER_TX_D = CH_D slice g and USER_TX_B = min(CH_B slice g, 8). This is 1-cycle latency from CH_RD to USER_TX_B.
  - On cycles without a pop, USER_TX_B = 0 and USER_TX_D holds its last value.
  - Each pop increments the burst counter and adds the clamped B to TX_BYTE_CNT.
  - If CH_B > 8, set ERR_BCNT; it clears only on reset.
  - Exit to IDLE (CH_GRANT = 0) at the edge after any of:
    - a pop with CH_LAST[g] = 1;
    - a pop making burst counter == MAX_BURST;
    - USER_SESSION_ESTABLISHED = 0, which aborts the packet mid-way with no further pops;
    - CH_ENABLE[g] = 0.
  - An empty FIFO mid-packet does not release the grant. The arbiter waits indefinitely. Packet atomicity wins over fairness.
  - There is 1 idle cycle between grants: max throughput is MAX_BURST words per MAX_BURST+1 cycles across channel changes.
- Simultaneous events:
  - A LAST pop coinciding with the burst limit exits once.
  - A session drop and a pop in the same cycle cannot occur, because the pop is gated by the session input.
- afull_q = 1 during XFER: no pops, grant held.
- RSTn asserted mid-burst: immediate return to reset state. Any FIFO word already popped is still consumed by the FIFO. Data is lost by design; the session restarts anyway.
- TX_BYTE_CNT wraps from 0xFFFFFFFF to 0 silently.

Test Plan:
1. Reset then session up; ch0 holds a 3-word packet (B=8,8,5, LAST on 3rd), others empty -> CH_GRANT=0001 one cycle later. CH_RD high 3 consecutive cycles. USER_TX_B = 8,8,5 each one cycle after its pop. TX_BYTE_CNT = 21. Then CH_GRANT = 0.
2. All 4 channels hold 1-word packets continuously -> grants cycle 0,1,2,3,0,… with exactly 1 IDLE cycle between words. After 8 packets each channel has sent 2.
3. MAX_BURST=4; ch1 holds a 10-word packet, ch2 non-empty -> ch1 pops 4 words, ch2 is granted, then ch1 resumes. USER_TX_B is never nonzero for two channels in the same cycle.
4. USER_TX_AFULL=1 for 5 cycles mid-burst -> CH_RD stops 1 cycle after AFULL rises and resumes 1 cycle after it falls. No word is duplicated or skipped (check by sequence numbers in D).
5. Session drops after word 2 of a 6-word packet -> no further CH_RD, CH_GRANT = 0 next cycle, TX_B = 0. No grant while the session is down, even with ch0..3 non-empty.
6. CH_B=12 on a popped word -> USER_TX_B = 8, ERR_BCNT = 1 and held. RSTn low asynchronously mid-burst -> all outputs 0 immediately, ERR_BCNT cleared.

Source files
------------

// File: rtl/sitcpxg_tx_arbiter.sv
// Round-robin arbiter that multiplexes NUM_CH FWFT user FIFOs onto the single
// SiTCPXG TCP transmit path. Grants hold for a whole packet, or for at most
// MAX_BURST words, with one idle cycle between consecutive grants.
module sitcpxg_tx_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int MAX_BURST = 256
) (
  input  logic                 XGMII_CLOCK,
  input  logic                 RSTn,
  input  logic                 USER_SESSION_ESTABLISHED,
  input  logic                 USER_TX_AFULL,
  output logic [63:0]          USER_TX_D,
  output logic [3:0]           USER_TX_B,
  input  logic [NUM_CH-1:0]    CH_ENABLE,
  input  logic [NUM_CH-1:0]    CH_EMPTY,
  input  logic [64*NUM_CH-1:0] CH_D,
  input  logic [4*NUM_CH-1:0]  CH_B,
  input  logic [NUM_CH-1:0]    CH_LAST,
  output logic [NUM_CH-1:0]    CH_RD,
  output logic [NUM_CH-1:0]    CH_GRANT,
  output logic [31:0]          TX_BYTE_CNT,
  output logic                 ERR_BCNT
);

  localparam int IW = $clog2(NUM_CH);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ST_IDLE,
    ST_XFER
  } state_t;

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              afull_q, afull_d;
  logic [63:0]       tx_d_q, tx_d_d;
  logic [3:0]        tx_b_q, tx_b_d;
  logic [31:0]       byte_cnt_q, byte_cnt_d;
  logic              err_q, err_d;

  logic [63:0]       ch_d_a [NUM_CH];
  logic [3:0]        ch_b_a [NUM_CH];
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] rd;
  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand;
  logic [63:0]       head_d;
  logic [3:0]        head_b;
  logic [3:0]        head_bc;
  logic              head_last;
  logic              pop;

  // Split the flat per-channel buses into indexable arrays.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_d_a[i] = CH_D[64*i +: 64];
    assign ch_b_a[i] = CH_B[4*i +: 4];
  end

  // Request vector and round-robin winner search starting after ptr_q.
  always_comb begin
    req       = CH_ENABLE & ~CH_EMPTY & {NUM_CH{USER_SESSION_ESTABLISHED}};
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = IW'((32'(ptr_q) + k) % NUM_CH);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Head word of the owning channel and the pop qualifier; ptr_q is the owner in XFER.
  always_comb begin
    head_d    = ch_d_a[ptr_q];
    head_b    = ch_b_a[ptr_q];
    head_bc   = (head_b > 4'd8) ? 4'd8 : head_b;
    head_last = CH_LAST[ptr_q];
    pop       = (state_q == ST_XFER) && !CH_EMPTY[ptr_q] && !afull_q &&
                USER_SESSION_ESTABLISHED && CH_ENABLE[ptr_q];
  end

  // Next-state, grant, datapath and counter updates.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    burst_d    = burst_q;
    afull_d    = USER_TX_AFULL;
    tx_d_d     = tx_d_q;
    tx_b_d     = '0;
    byte_cnt_d = byte_cnt_q;
    err_d      = err_q;
    rd         = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          ptr_d            = win_idx;
          burst_d          = '0;
          state_d          = ST_XFER;
        end
      end
      ST_XFER: begin
        rd[ptr_q] = pop;
        if (pop) begin
          tx_d_d     = head_d;
          tx_b_d     = head_bc;
          byte_cnt_d = byte_cnt_q + 32'(head_bc);
          burst_d    = burst_q + 1'b1;
          if (head_b > 4'd8) err_d = 1'b1;
        end
        // LAST and burst limit on the same pop collapse into one exit.
        if ((pop && (head_last || (burst_q == BW'(MAX_BURST - 1)))) ||
            !USER_SESSION_ESTABLISHED || !CH_ENABLE[ptr_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers; almost-full resets asserted so nothing pops before it is sampled.
  always_ff @(posedge XGMII_CLOCK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ptr_q      <= IW'(NUM_CH - 1);
      burst_q    <= '0;
      afull_q    <= 1'b1;
      tx_d_q     <= '0;
      tx_b_q     <= '0;
      byte_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      burst_q    <= burst_d;
      afull_q    <= afull_d;
      tx_d_q     <= tx_d_d;
      tx_b_q     <= tx_b_d;
      byte_cnt_q <= byte_cnt_d;
      err_q      <= err_d;
    end
  end

  assign CH_RD       = rd;
  assign CH_GRANT    = grant_q;
  assign USER_TX_D   = tx_d_q;
  assign USER_TX_B   = tx_b_q;
  assign TX_BYTE_CNT = byte_cnt_q;
  assign ERR_BCNT    = err_q;

endmodule

// File: tb/tb_sitcpxg_tx_arbiter.sv
// Scoreboard bench for sitcpxg_tx_arbiter: models the user FIFOs, records
// every pop, and checks the word that must appear one cycle later.
module tb_sitcpxg_tx_arbiter;

  localparam int NUM_CH    = 4;
  localparam int MAX_BURST = 4;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         session;
  logic                         afull;
  logic [NUM_CH-1:0]            ch_enable;
  logic [NUM_CH-1:0]            ch_empty;
  logic [NUM_CH-1:0]            ch_last;
  logic [NUM_CH-1:0][63:0]      ch_d_a;
  logic [NUM_CH-1:0][3:0]       ch_b_a;
  logic [NUM_CH-1:0]            ch_rd;
  logic [NUM_CH-1:0]            ch_grant;
  logic [63:0]                  tx_d;
  logic [3:0]                   tx_b;
  logic [31:0]                  tx_cnt;
  logic                         err;

  sitcpxg_tx_arbiter #(.NUM_CH(NUM_CH), .MAX_BURST(MAX_BURST)) dut (
    .XGMII_CLOCK              (clk),
    .RSTn                     (rst_n),
    .USER_SESSION_ESTABLISHED (session),
    .USER_TX_AFULL            (afull),
    .USER_TX_D                (tx_d),
    .USER_TX_B                (tx_b),
    .CH_ENABLE                (ch_enable),
    .CH_EMPTY                 (ch_empty),
    .CH_D                     (ch_d_a),
    .CH_B                     (ch_b_a),
    .CH_LAST                  (ch_last),
    .CH_RD                    (ch_rd),
    .CH_GRANT                 (ch_grant),
    .TX_BYTE_CNT              (tx_cnt),
    .ERR_BCNT                 (err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cycle   = 0;
  int          seq     = 0;
  logic [68:0] fq [NUM_CH][$];   // {last, b[3:0], d[63:0]}
  logic        afull_r;
  logic        have_exp;
  logic [63:0] exp_d;
  logic [3:0]  exp_b;
  logic [31:0] exp_bytes;
  logic        exp_err;
  int          pop_ch[$];
  int          pop_cyc[$];
  logic [63:0] rx_d[$];
  logic [63:0] pushed[$];

  function automatic logic [3:0] clampb(input logic [3:0] b);
    return (b > 4'd8) ? 4'd8 : b;
  endfunction

  task automatic push_word(input int ch, input logic [3:0] b, input logic last);
    logic [1:0]  ci;
    logic [63:0] d;
    ci = 2'(ch);
    d  = {8'(ch), 24'h0, 32'(seq)};
    seq++;
    fq[ci].push_back({last, b, d});
    pushed.push_back(d);
  endtask

  // One clock: check outputs at negedge, book any pop, then refresh FIFO heads.
  task automatic tick();
    logic [NUM_CH-1:0] rd_exp;
    logic [68:0]       e;
    logic [1:0]        ci;
    @(negedge clk);
    n_tests++;
    if (have_exp) begin
      if (tx_b !== exp_b || tx_d !== exp_d) begin
        n_fail++;
        $display("FAIL sb_word cyc=%0d got B=%0d D=%h exp B=%0d D=%h", cycle, tx_b, tx_d, exp_b, exp_d);
      end
      rx_d.push_back(tx_d);
    end else if (tx_b !== 4'd0) begin
      n_fail++;
      $display("FAIL idle_b cyc=%0d got B=%0d exp 0", cycle, tx_b);
    end
    rd_exp = ch_grant & ~ch_empty & ch_enable & {NUM_CH{session}} & {NUM_CH{~afull_r}};
    n_tests++;
    if (ch_rd !== rd_exp) begin
      n_fail++;
      $display("FAIL ch_rd cyc=%0d got %b exp %b", cycle, ch_rd, rd_exp);
    end
    n_tests++;
    if (!$onehot0(ch_grant)) begin
      n_fail++;
      $display("FAIL grant_onehot cyc=%0d got %b exp one-hot or zero", cycle, ch_grant);
    end
    n_tests++;
    if (tx_cnt !== exp_bytes || err !== exp_err) begin
      n_fail++;
      $display("FAIL cnt_err cyc=%0d got cnt=%0d err=%b exp cnt=%0d err=%b", cycle, tx_cnt, err, exp_bytes, exp_err);
    end
    have_exp = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      ci = 2'(i);
      if (ch_rd[ci] && !have_exp) begin
        n_tests++;
        if (fq[ci].size() == 0) begin
          n_fail++;
          $display("FAIL pop_empty cyc=%0d ch=%0d got pop exp none", cycle, i);
        end else begin
          e         = fq[ci].pop_front();
          exp_d     = e[63:0];
          exp_b     = clampb(e[67:64]);
          exp_bytes = exp_bytes + 32'(exp_b);
          if (e[67:64] > 4'd8) exp_err = 1'b1;
          have_exp  = 1'b1;
          pop_ch.push_back(i);
          pop_cyc.push_back(cycle);
        end
      end
    end
    @(posedge clk);
    afull_r = rst_n ? afull : 1'b1;
    cycle++;
    #1;
    for (int c = 0; c < NUM_CH; c++) begin
      ci = 2'(c);
      if (fq[ci].size() == 0) begin
        ch_empty[ci] = 1'b1;
        ch_d_a[ci]   = '0;
        ch_b_a[ci]   = '0;
        ch_last[ci]  = 1'b0;
      end else begin
        e            = fq[ci][0];
        ch_empty[ci] = 1'b0;
        ch_d_a[ci]   = e[63:0];
        ch_b_a[ci]   = e[67:64];
        ch_last[ci]  = e[68];
      end
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < NUM_CH; c++) fq[2'(c)].delete();
    have_exp  = 1'b0;
    exp_bytes = '0;
    exp_err   = 1'b0;
    afull_r   = 1'b1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    session   = 1'b0;
    afull     = 1'b0;
    ch_enable = '1;
    clear_model();
    repeat (3) tick();
    rst_n   = 1'b1;
    session = 1'b1;
    tick();
    pop_ch.delete();
    pop_cyc.delete();
    rx_d.delete();
    pushed.delete();
  endtask

  task automatic run_pops(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (pop_ch.size() < n && k < budget) begin
      tick();
      k++;
    end
    n_tests++;
    if (pop_ch.size() < n) begin
      n_fail++;
      $display("FAIL %s_timeout got %0d pops exp %0d", name, pop_ch.size(), n);
    end
  endtask

  task automatic test_reset();
    #2;
    n_tests++;
    if ({tx_d, tx_b, ch_rd, ch_grant, tx_cnt, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got D=%h B=%0d rd=%b g=%b cnt=%0d err=%b exp all 0", tx_d, tx_b, ch_rd, ch_grant, tx_cnt, err);
    end
    do_reset();
    n_tests++;
    if (ch_grant !== 4'b0000 || tx_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL post_reset got g=%b cnt=%0d exp 0000 0", ch_grant, tx_cnt);
    end
  endtask

  task automatic test_single_packet();
    push_word(0, 4'd8, 1'b0);
    push_word(0, 4'd8, 1'b0);
    push_word(0, 4'd5, 1'b1);
    tick();
    tick();
    n_tests++;
    if (ch_grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL first_grant got %b exp 0001", ch_grant);
    end
    run_pops(3, 20, "single");
    n_tests++;
    if (pop_ch.size() >= 3 && (pop_cyc[2] - pop_cyc[0] != 2 || pop_ch[2] != 0)) begin
      n_fail++;
      $display("FAIL single_consec got span=%0d exp 2", pop_cyc[2] - pop_cyc[0]);
    end
    tick();
    n_tests++;
    if (tx_cnt !== 32'd21 || ch_grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_end got cnt=%0d g=%b exp 21 0000", tx_cnt, ch_grant);
    end
  endtask

  task automatic test_round_robin();
    int exp_ch;
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NUM_CH; c++)
        push_word(c, 4'(c + 1 + 4 * r), 1'b1);
    run_pops(8, 60, "rr");
    for (int k = 0; k < pop_ch.size(); k++) begin
      exp_ch = k % NUM_CH;
      n_tests++;
      if (pop_ch[k] != exp_ch) begin
        n_fail++;
        $display("FAIL rr_order idx=%0d got ch%0d exp ch%0d", k, pop_ch[k], exp_ch);
      end
      if (k > 0) begin
        n_tests++;
        if (pop_cyc[k] - pop_cyc[k-1] != 2) begin
          n_fail++;
          $display("FAIL rr_gap idx=%0d got %0d exp 2", k, pop_cyc[k] - pop_cyc[k-1]);
        end
      end
    end
    tick();
  endtask

  task automatic test_burst_limit();
    int exp_ch  [12] = '{1, 1, 1, 1, 2, 2, 1, 1, 1, 1, 1, 1};
    int exp_gap [12] = '{0, 1, 1, 1, 2, 1, 2, 1, 1, 1, 2, 1};
    do_reset();
    for (int w = 0; w < 10; w++) push_word(1, 4'd8, w == 9);
    push_word(2, 4'd3, 1'b0);
    push_word(2, 4'd4, 1'b1);
    run_pops(12, 80, "burst");
    for (int k = 0; k < 12 && k < pop_ch.size(); k++) begin
      n_tests++;
      if (pop_ch[k] != exp_ch[k] || (k > 0 && pop_cyc[k] - pop_cyc[k-1] != exp_gap[k])) begin
        n_fail++;
        $display("FAIL burst_seq idx=%0d got ch%0d gap=%0d exp ch%0d gap=%0d", k, pop_ch[k],
                 (k > 0) ? pop_cyc[k] - pop_cyc[k-1] : 0, exp_ch[k], exp_gap[k]);
      end
    end
    tick();
  endtask

  task automatic test_afull();
    do_reset();
    for (int w = 0; w < 12; w++) push_word(0, 4'd8, w == 11);
    run_pops(2, 20, "afull_pre");
    afull = 1'b1;
    repeat (5) tick();
    afull = 1'b0;
    n_tests++;
    if (pop_ch.size() != 3 || ch_grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL afull_stall got pops=%0d g=%b exp 3 0001", pop_ch.size(), ch_grant);
    end
    tick();
    n_tests++;
    if (pop_ch.size() != 3) begin
      n_fail++;
      $display("FAIL afull_release_lag got pops=%0d exp 3", pop_ch.size());
    end
    tick();
    n_tests++;
    if (pop_ch.size() != 4) begin
      n_fail++;
      $display("FAIL afull_resume got pops=%0d exp 4", pop_ch.size());
    end
    run_pops(12, 60, "afull_drain");
    tick();
    n_tests++;
    if (rx_d.size() != 12) begin
      n_fail++;
      $display("FAIL afull_count got %0d words exp 12", rx_d.size());
    end
    for (int k = 0; k < 12 && k < rx_d.size(); k++) begin
      n_tests++;
      if (rx_d[k] !== pushed[k]) begin
        n_fail++;
        $display("FAIL afull_seq idx=%0d got %h exp %h", k, rx_d[k], pushed[k]);
      end
    end
  endtask

  task automatic test_session_drop();
    int exp_ch [9] = '{0, 0, 1, 2, 3, 0, 0, 0, 0};
    do_reset();
    for (int w = 0; w < 6; w++) push_word(0, 4'd8, w == 5);
    for (int c = 1; c < NUM_CH; c++) push_word(c, 4'd2, 1'b1);
    run_pops(2, 20, "drop_pre");
    session = 1'b0;
    tick();
    n_tests++;
    if (ch_grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL drop_grant got %b exp 0000", ch_grant);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      n_tests++;
      if (ch_grant !== 4'b0000 || pop_ch.size() != 2) begin
        n_fail++;
        $display("FAIL drop_idle k=%0d got g=%b pops=%0d exp 0000 2", k, ch_grant, pop_ch.size());
      end
    end
    session = 1'b1;
    run_pops(9, 60, "drop_resume");
    tick();
    for (int k = 0; k < 9 && k < pop_ch.size(); k++) begin
      n_tests++;
      if (pop_ch[k] != exp_ch[k]) begin
        n_fail++;
        $display("FAIL drop_order idx=%0d got ch%0d exp ch%0d", k, pop_ch[k], exp_ch[k]);
      end
    end
    n_tests++;
    if (ch_grant !== 4'b0000 || ch_empty !== 4'b1111) begin
      n_fail++;
      $display("FAIL drop_end got g=%b empty=%b exp 0000 1111", ch_grant, ch_empty);
    end
  endtask

  task automatic test_bcnt_async_reset();
    do_reset();
    push_word(3, 4'd12, 1'b0);
    for (int w = 0; w < 5; w++) push_word(3, 4'd8, w == 4);
    run_pops(1, 20, "bcnt");
    n_tests++;
    if (tx_b !== 4'd8 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL bcnt_clamp got B=%0d err=%b exp 8 1", tx_b, err);
    end
    run_pops(3, 20, "bcnt_more");
    n_tests++;
    if (err !== 1'b1 || ch_grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL bcnt_sticky got err=%b g=%b exp 1 1000", err, ch_grant);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({tx_d, tx_b, ch_rd, ch_grant, tx_cnt, err} !== '0) begin
      n_fail++;
      $display("FAIL async_reset got D=%h B=%0d rd=%b g=%b cnt=%0d err=%b exp all 0", tx_d, tx_b, ch_rd, ch_grant, tx_cnt, err);
    end
    clear_model();
    do_reset();
  endtask

  initial begin
    rst_n     = 1'b0;
    session   = 1'b0;
    afull     = 1'b0;
    ch_enable = '1;
    ch_empty  = '1;
    ch_last   = '0;
    ch_d_a    = '0;
    ch_b_a    = '0;
    afull_r   = 1'b1;
    have_exp  = 1'b0;
    exp_d     = '0;
    exp_b     = '0;
    exp_bytes = '0;
    exp_err   = 1'b0;
    test_reset();
    test_single_packet();
    test_round_robin();
    test_burst_limit();
    test_afull();
    test_session_drop();
    test_bcnt_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
